fifo_flops: RTL and testbench
=============================

// Module: fifo_flops
// PURPOSE
//  Synchronous first-in/first-out queue built entirely from flip-flops (no RAM macro).
//  Stores up to 'depth' words of width 'bits'.
//  Producer side: push/Din. Consumer side: pop/Dout. Status outputs: full, pndng (data pending).
//  Generic buffering element between bus agents; also the reference DUT for FIFO verification benches.
// PARAMETERS
//  bits   32  data word width in bits
//  depth  16  number of storage entries; any value >= 2 (need not be a power of 2)
// PORTS
//  clk    in   1     single clock; all state updates on rising edge
//  rst    in   1     synchronous, active-high reset (sampled on posedge clk)
//  Din    in   bits  write data, captured when push=1
//  push   in   1     write request
//  pop    in   1     read request; removes the head entry
//  Dout   out  bits  head-of-queue data (oldest entry)
//  full   out  1     1 when count == depth
//  pndng  out  1     1 when count != 0
// BEHAVIOUR
//  - Internal occupancy register 'count', width $clog2(depth)+1, named exactly 'count'.
//    Benches read it hierarchically (DUT.count).
//  - Reset (rst=1 at posedge): count=0 and all storage words=0. Hence full=0, pndng=0, Dout=0.
//    rst has priority over push/pop. Mid-operation reset discards all contents in that cycle.
//  - Storage is a shift-register queue: entry 0 is the head.
//  - Push only (push=1, pop=0, not full): mem[count]<=Din; count+1. Visible at Dout next cycle if queue was empty.
//  - Pop only (pop=1, push=0, not empty): mem[i]<=mem[i+1] for all i; top entry<=0; count-1.
//  - Push+pop, 0<count<depth: shift as for pop; Din written to mem[count-1]; count unchanged.
//  - Push+pop when full: same as previous case; count stays depth, full stays 1.
//  - Push+pop when empty: pop ignored, push performed; count becomes 1.
//  - Push while full (no pop): Din dropped; storage and count unchanged (no overwrite).
//  - Pop while empty: no effect; count stays 0; Dout stays 0.
//  - Dout = mem[0], combinational from the registers (no extra latency after the state update).
//    Entries vacated by a pop are cleared, so Dout=0 whenever count==0.
//  - full/pndng: combinational decodes of count; they change in the cycle after the causing edge.
//  - Din is sampled only when a push is accepted.
//  - count never wraps: saturates logically at 0 and depth per the rules above.
// STRUCTURE
//  - Shared package fifo_pkg:
//    FIFO_BITS=32, FIFO_DEPTH=16 defaults;
//    typedef logic [FIFO_BITS-1:0] fifo_word_t;
//    count width function/constant.
//  - One natural sub-module: fifo_flops_stage.
//    One storage word register with synchronous reset and a 2:1 input select:
//    hold / load Din / load next stage.
//    Instantiated depth times via generate; top-level holds count logic and the output mux.
// TESTING
//  1 Reset: rst=1 for 1 cycle -> count=0, full=0, pndng=0, Dout=0.
//  2 Fill: push 0,1,2,...,15 on consecutive pushes -> count increments each push;
//    after 16th push full=1, pndng=1, Dout=0.
//  3 Overflow: push 99 while full -> count stays 16; contents unchanged;
//    later pops return 0..15 in order, 99 never appears.
//  4 Drain: pop 16 times -> Dout sequence 0,1,...,15; after last pop pndng=0, count=0, Dout=0;
//    an extra pop leaves count=0.
//  5 Simultaneous: with count=3 (data 5,6,7), push=1 Din=8 pop=1 -> count=3, Dout=6, queue 6,7,8;
//    repeat when full -> full stays 1.
//  6 Reset mid-operation: count=5, assert rst together with push=1 -> count=0, pndng=0, Din not stored.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, word type and occupancy-counter width for the flop FIFO
package fifo_pkg;
    localparam int FIFO_BITS  = 32;
    localparam int FIFO_DEPTH = 16;
    typedef logic [FIFO_BITS-1:0] fifo_word_t;
    function automatic int fifo_cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction
    localparam int FIFO_CNT_W = fifo_cnt_w(FIFO_DEPTH);
endpackage

// File: rtl/fifo_flops_stage.sv
// fifo_flops_stage: one storage word that holds, loads Din, or takes the word from the stage above
module fifo_flops_stage
    import fifo_pkg::*;
#(
    parameter int bits = FIFO_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_shift,
    input  logic [bits-1:0] i_din,
    input  logic [bits-1:0] i_next,
    output logic [bits-1:0] o_q
);
    logic [bits-1:0] r_q;
    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else if (i_load) r_q <= i_din;
        else if (i_shift) r_q <= i_next;
    end
    assign o_q = r_q;
endmodule

// File: rtl/fifo_flops.sv
// fifo_flops: flip-flop shift-register FIFO; entry 0 is the head and drives Dout
module fifo_flops
    import fifo_pkg::*;
#(
    parameter int bits  = FIFO_BITS,
    parameter int depth = FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] Din,
    input  logic            push,
    input  logic            pop,
    output logic [bits-1:0] Dout,
    output logic            full,
    output logic            pndng
);
    localparam int CW = fifo_cnt_w(depth);
    logic [CW-1:0]   count;
    logic [bits-1:0] w_q [depth];
    logic            w_full, w_empty, w_push, w_pop;
    logic [CW-1:0]   w_widx;
    assign w_full  = count == CW'(depth);
    assign w_empty = count == '0;
    assign w_pop   = pop && !w_empty;
    // a pop frees a slot in the same cycle, so push is accepted when full if popping
    assign w_push  = push && (!w_full || w_pop);
    assign w_widx  = w_pop ? count - 1'b1 : count;
    for (genvar i = 0; i < depth; i++) begin : g_stage
        logic [bits-1:0] w_next;
        if (i == depth - 1) begin : g_top
            assign w_next = '0;
        end else begin : g_mid
            assign w_next = w_q[i+1];
        end
        fifo_flops_stage #(.bits(bits)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_push && w_widx == CW'(i)),
            .i_shift(w_pop),
            .i_din  (Din),
            .i_next (w_next),
            .o_q    (w_q[i])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else count <= count + CW'(w_push) - CW'(w_pop);
    end
    assign Dout  = w_q[0];
    assign full  = w_full;
    assign pndng = !w_empty;
endmodule

// File: tb/tb_fifo_flops.sv
// tb_fifo_flops: directed vectors with hand-computed expectations for the flop FIFO
module tb_fifo_flops;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] Din = 0;
    logic        push = 0;
    logic        pop = 0;
    logic [31:0] Dout;
    logic        full, pndng;
    int          n_vec = 0;
    int          n_err = 0;

    fifo_flops #(.bits(32), .depth(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .push (push),
        .pop  (pop),
        .Dout (Dout),
        .full (full),
        .pndng(pndng)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic pu, input logic po, input logic [31:0] d);
        rst = r; push = pu; pop = po; Din = d;
        @(posedge clk);
        #1;
        rst = 0; push = 0; pop = 0;
    endtask

    initial begin
        step(1, 0, 0, 0);
        check("rst_count", 32'(dut.count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_pndng", 32'(pndng), 0);
        check("rst_dout", Dout, 0);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 32'(i));
            check("fill_count", 32'(dut.count), 32'(i + 1));
            check("fill_dout", Dout, 0);
            check("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
        end
        check("fill_pndng", 32'(pndng), 1);

        step(0, 1, 0, 99);
        check("ovf_count", 32'(dut.count), 16);
        check("ovf_full", 32'(full), 1);
        check("ovf_dout", Dout, 0);

        for (int i = 0; i < 16; i++) begin
            check("drain_dout", Dout, 32'(i));
            step(0, 0, 1, 0);
            check("drain_count", 32'(dut.count), 32'(15 - i));
        end
        check("drain_pndng", 32'(pndng), 0);
        check("drain_dout0", Dout, 0);
        step(0, 0, 1, 0);
        check("xpop_count", 32'(dut.count), 0);
        check("xpop_dout", Dout, 0);

        step(0, 1, 0, 5);
        step(0, 1, 0, 6);
        step(0, 1, 0, 7);
        check("sim_pre_count", 32'(dut.count), 3);
        step(0, 1, 1, 8);
        check("sim_count", 32'(dut.count), 3);
        check("sim_dout", Dout, 6);
        step(0, 0, 1, 0);
        check("sim_q1", Dout, 7);
        step(0, 0, 1, 0);
        check("sim_q2", Dout, 8);
        check("sim_q2_count", 32'(dut.count), 1);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 32'(9 + i));
        check("refill_full", 32'(full), 1);
        step(0, 1, 1, 50);
        check("simf_full", 32'(full), 1);
        check("simf_count", 32'(dut.count), 16);
        check("simf_dout", Dout, 9);
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
        check("simf_dout_tail2", Dout, 23);
        step(0, 0, 1, 0);
        check("simf_dout_tail1", Dout, 50);
        check("simf_tail_count", 32'(dut.count), 1);

        step(1, 0, 0, 0);
        step(0, 1, 1, 42);
        check("pp_empty_count", 32'(dut.count), 1);
        check("pp_empty_dout", Dout, 42);

        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'(100 + i));
        check("mid_pre_count", 32'(dut.count), 5);
        check("mid_pre_dout", Dout, 100);
        step(1, 1, 0, 77);
        check("mid_count", 32'(dut.count), 0);
        check("mid_pndng", 32'(pndng), 0);
        check("mid_dout", Dout, 0);
        step(0, 0, 0, 0);
        check("mid_after_dout", Dout, 0);
        check("mid_after_count", 32'(dut.count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
